// File: rtl/morph_pkg.sv
// Shared types and helpers for the 3x3 binary morphology stages.
package morph_pkg;

   localparam logic OP_ERODE  = 1'b0;
   localparam logic OP_DILATE = 1'b1;

   // Pixel plus its de tag, as stored in the window and second line buffer.
   typedef struct packed {
      logic pix;
      logic de;
   } tap_t;

   // Full stream word; sync bits only travel through the centre path.
   typedef struct packed {
      logic pix;
      logic de;
      logic hsync;
      logic vsync;
   } px_t;

   // Value that leaves an AND/OR reduction unchanged.
   function automatic logic NEUTRAL(input logic op);
      return (op == OP_ERODE);
   endfunction

   function automatic int STAGE_LAT(input int h);
      return h + 2;
   endfunction

endpackage

// File: rtl/morph3x3_stage.sv
// One 3x3 erosion (OP_ERODE) or dilation (OP_DILATE) stage with its own line
// buffers; centre tap lags the newest tap by H_SIZE+1, output is registered.
module morph3x3_stage
   import morph_pkg::*;
#(
   parameter int   H_SIZE = 83,
   parameter logic OP     = OP_ERODE
) (
   input  logic clk,
   input  logic rst,
   input  logic ce,
   input  logic in_pix,
   input  logic in_de,
   input  logic in_hsync,
   input  logic in_vsync,
   output logic out_pix,
   output logic out_de,
   output logic out_hsync,
   output logic out_vsync
);

   px_t        in_word;
   px_t        lb1_reg [H_SIZE];
   tap_t       lb2_reg [H_SIZE];
   tap_t       row0_reg [2];
   px_t        ctr_reg;
   tap_t       row1_old_reg;
   tap_t       row2_reg [2];
   tap_t       taps [9];
   logic [8:0] eff;
   logic       result;

   assign in_word = {in_pix, in_de, in_hsync, in_vsync};

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < H_SIZE; i++) begin
            lb1_reg[i] <= '0;
            lb2_reg[i] <= '0;
         end
         for (int i = 0; i < 2; i++) begin
            row0_reg[i] <= '0;
            row2_reg[i] <= '0;
         end
         ctr_reg      <= '0;
         row1_old_reg <= '0;
         out_pix      <= 1'b0;
         out_de       <= 1'b0;
         out_hsync    <= 1'b0;
         out_vsync    <= 1'b0;
      end else if (ce) begin
         lb1_reg[0] <= in_word;
         lb2_reg[0] <= {lb1_reg[H_SIZE-1].pix, lb1_reg[H_SIZE-1].de};
         for (int i = 1; i < H_SIZE; i++) begin
            lb1_reg[i] <= lb1_reg[i-1];
            lb2_reg[i] <= lb2_reg[i-1];
         end
         row0_reg[0]  <= {in_pix, in_de};
         row0_reg[1]  <= row0_reg[0];
         ctr_reg      <= lb1_reg[H_SIZE-1];
         row1_old_reg <= {ctr_reg.pix, ctr_reg.de};
         row2_reg[0]  <= lb2_reg[H_SIZE-1];
         row2_reg[1]  <= row2_reg[0];
         // Outside the active area the pixel is meaningless, so force it low.
         out_pix      <= ctr_reg.de & result;
         out_de       <= ctr_reg.de;
         out_hsync    <= ctr_reg.hsync;
         out_vsync    <= ctr_reg.vsync;
      end
   end

   always_comb begin
      taps[0] = {in_pix, in_de};
      taps[1] = row0_reg[0];
      taps[2] = row0_reg[1];
      taps[3] = {lb1_reg[H_SIZE-1].pix, lb1_reg[H_SIZE-1].de};
      taps[4] = {ctr_reg.pix, ctr_reg.de};
      taps[5] = row1_old_reg;
      taps[6] = lb2_reg[H_SIZE-1];
      taps[7] = row2_reg[0];
      taps[8] = row2_reg[1];
   end

   // Invalid taps take the neutral value, which handles every frame border.
   for (genvar gi = 0; gi < 9; gi++) begin : g_sub
      assign eff[gi] = taps[gi].de ? taps[gi].pix : NEUTRAL(OP);
   end

   assign result = (OP == OP_ERODE) ? (&eff) : (|eff);

endmodule

// File: rtl/opening3x3.sv
// 3x3 morphological opening (erode then dilate) of a 1-bit mask stream.
// Optional per-frame foreground pixel counter enabled by OPENING_STATS_EN.
module opening3x3
   import morph_pkg::*;
#(
   parameter int H_SIZE = 83
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ce,
   input  logic        mask,
   input  logic        in_de,
   input  logic        in_vsync,
   input  logic        in_hsync,
   output logic        opened,
   output logic        out_de,
   output logic        out_vsync,
   output logic        out_hsync
`ifdef OPENING_STATS_EN
   ,
   output logic [15:0] fg_count,
   output logic        fg_count_valid
`endif
);

   logic ero_pix;
   logic ero_de;
   logic ero_hsync;
   logic ero_vsync;

   morph3x3_stage #(.H_SIZE(H_SIZE), .OP(OP_ERODE)) u_erode (
      .clk       (clk),
      .rst       (rst),
      .ce        (ce),
      .in_pix    (mask),
      .in_de     (in_de),
      .in_hsync  (in_hsync),
      .in_vsync  (in_vsync),
      .out_pix   (ero_pix),
      .out_de    (ero_de),
      .out_hsync (ero_hsync),
      .out_vsync (ero_vsync)
   );

   morph3x3_stage #(.H_SIZE(H_SIZE), .OP(OP_DILATE)) u_dilate (
      .clk       (clk),
      .rst       (rst),
      .ce        (ce),
      .in_pix    (ero_pix),
      .in_de     (ero_de),
      .in_hsync  (ero_hsync),
      .in_vsync  (ero_vsync),
      .out_pix   (opened),
      .out_de    (out_de),
      .out_hsync (out_hsync),
      .out_vsync (out_vsync)
   );

`ifdef OPENING_STATS_EN
   logic [15:0] cnt_reg;
   logic        vsync_prev_reg;
   logic        rise;
   logic        inc;

   assign rise = ce & out_vsync & ~vsync_prev_reg;
   assign inc  = ce & out_de & opened;

   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt_reg        <= '0;
         vsync_prev_reg <= 1'b0;
         fg_count       <= '0;
         fg_count_valid <= 1'b0;
      end else begin
         fg_count_valid <= rise;
         if (rise) begin
            fg_count <= cnt_reg;
            cnt_reg  <= {15'd0, inc};
         end else if (inc && cnt_reg != 16'hFFFF) begin
            cnt_reg <= cnt_reg + 16'd1;
         end
         if (ce) vsync_prev_reg <= out_vsync;
      end
   end
`endif

endmodule

// File: tb/tb_opening3x3.sv
// Directed bench for opening3x3 at H_SIZE=10 (6 active + 4 blank per line).
module tb_opening3x3;

   localparam int H   = 10;
   localparam int LAT = 2*H + 4;

   localparam logic [23:0] BLK3  = {6'b011100, 6'b011100, 6'b011100, 6'b000000};
   localparam logic [23:0] SPECK = {6'b000000, 6'b000000, 6'b000100, 6'b000000};
   localparam logic [23:0] HLINE = {6'b000000, 6'b000000, 6'b001110, 6'b000000};
   localparam logic [23:0] ONES  = 24'hFFFFFF;
   localparam logic [23:0] BLK4  = {4{6'b011110}};
   localparam logic [23:0] ZERO  = 24'h000000;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic ce = 1'b1;
   logic mask = 1'b0;
   logic in_de = 1'b0;
   logic in_vsync = 1'b0;
   logic in_hsync = 1'b0;
   logic opened;
   logic out_de;
   logic out_vsync;
   logic out_hsync;
`ifdef OPENING_STATS_EN
   logic [15:0] fg_count;
   logic        fg_count_valid;
   logic [15:0] m_cnt = '0;
   logic [15:0] m_fg = '0;
   bit          m_valid = 0;
   bit          m_vprev = 0;
   bit          m_known = 1;
   bit          m_fg_known = 1;
`endif

   opening3x3 #(.H_SIZE(H)) dut (
      .clk       (clk),
      .rst       (rst),
      .ce        (ce),
      .mask      (mask),
      .in_de     (in_de),
      .in_vsync  (in_vsync),
      .in_hsync  (in_hsync),
      .opened    (opened),
      .out_de    (out_de),
      .out_vsync (out_vsync),
      .out_hsync (out_hsync)
`ifdef OPENING_STATS_EN
      ,
      .fg_count       (fg_count),
      .fg_count_valid (fg_count_valid)
`endif
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int n = 0;
   int zero_base = 0;
   int frame_no = 0;
   bit rst_prev = 1;
   bit frame_known = 1;
   bit de_h [4096];
   bit hs_h [4096];
   bit vs_h [4096];
   bit px_h [4096];
   bit pk_h [4096];

   task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s idx=%0d: got %0h expected %0h", tag, n, got, exp);
      end
   endtask

   // Expected outputs for the cycle whose enabled index is idx.
   task automatic expect_at(input int idx, output logic o, output logic d,
                            output logic h, output logic v, output bit k);
      int m;
      m = idx - LAT;
      if (m < zero_base) begin
         o = 0; d = 0; h = 0; v = 0; k = 1;
      end else begin
         o = px_h[m]; d = de_h[m]; h = hs_h[m]; v = vs_h[m]; k = pk_h[m];
      end
   endtask

   task automatic cyc(input bit en, input bit r, input bit m_in, input bit d_in,
                      input bit h_in, input bit v_in, input bit p_exp);
      logic eo, ed, eh, ev;
      bit   ek;
`ifdef OPENING_STATS_EN
      bit   rise, inc, unk;
`endif
      ce = en; rst = !r; mask = m_in; in_de = d_in; in_hsync = h_in; in_vsync = v_in;
      @(negedge clk);
      if (rst_prev) begin
         eo = 0; ed = 0; eh = 0; ev = 0; ek = 1;
      end else begin
         expect_at(n, eo, ed, eh, ev, ek);
      end
      check_eq("out_de", out_de, ed);
      check_eq("out_hsync", out_hsync, eh);
      check_eq("out_vsync", out_vsync, ev);
      if (ek) check_eq("opened", opened, eo);
`ifdef OPENING_STATS_EN
      check_eq("fg_count_valid", fg_count_valid, m_valid);
      if (m_valid && m_fg_known) check_eq("fg_count", fg_count, m_fg);
      if (r) begin
         m_cnt = '0; m_fg = '0; m_valid = 0; m_vprev = 0; m_known = 1; m_fg_known = 1;
      end else begin
         rise = en && ev && !m_vprev;
         inc  = en && ed && eo;
         unk  = en && ed && !ek;
         m_valid = rise;
         if (rise) begin
            m_fg = m_cnt; m_fg_known = m_known;
            m_cnt = inc ? 16'd1 : 16'd0; m_known = !unk;
         end else begin
            if (inc && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
            if (unk) m_known = 0;
         end
         if (en) m_vprev = ev;
      end
`endif
      if (r) begin
         zero_base = n;
      end else if (en) begin
         de_h[n] = d_in; hs_h[n] = h_in; vs_h[n] = v_in;
         px_h[n] = d_in & p_exp;
         pk_h[n] = frame_known || !d_in;
         n++;
      end
      rst_prev = r;
      @(posedge clk);
      #1;
   endtask

   // One frame: line 0 vsync, line 1 blank, lines 2..5 active, lines 6..7 blank.
   task automatic run_frame(input logic [23:0] img, input logic [23:0] eimg,
                            input bit toggle, input int rst_pos);
      int errs_before;
      errs_before = errors;
      frame_known = 1;
      for (int pos = 0; pos < 80; pos++) begin
         int  ln;
         int  col;
         int  idx;
         bit  act;
         ln  = pos / 10;
         col = pos % 10;
         act = (ln >= 2) && (ln <= 5) && (col < 6);
         idx = act ? (ln - 2) * 6 + col : 0;
         if (pos == rst_pos) begin
            repeat (3) cyc(1, 1, 0, 0, 0, 0, 0);
            frame_known = 0;
         end
         if (toggle)
            cyc(0, 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
         cyc(1, 0, act ? img[idx] : 1'b1, act, (col == 6) || (col == 7), ln == 0,
             act ? eimg[idx] : 1'b0);
      end
      $display("frame %0d: img=%06h toggle=%0d rst_pos=%0d new_errors=%0d",
               frame_no, img, toggle, rst_pos, errors - errs_before);
      frame_no++;
   endtask

   initial begin
      @(posedge clk);
      #1;
      repeat (3) cyc(1, 1, 0, 0, 0, 0, 0);
      run_frame(BLK3,  BLK3, 0, -1);
      run_frame(SPECK, ZERO, 0, -1);
      run_frame(HLINE, ZERO, 0, -1);
      run_frame(ONES,  ONES, 0, -1);
      run_frame(BLK4,  BLK4, 0, -1);
      run_frame(BLK4,  BLK4, 1, -1);
      run_frame(BLK4,  BLK4, 0, 42);
      run_frame(ONES,  ONES, 0, -1);
      run_frame(ZERO,  ZERO, 0, -1);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/opening3x3.md
Name: opening3x3

Overview:
- Morphological opening of a 1-bit skin mask stream: a 3x3 erosion followed by a 3x3 dilation. It is the dual of the existing closing stage.
- It removes isolated foreground specks and thin protrusions narrower than 3 px.
- It sits in the skin-colour segmentation chain, either before or after closing, on the same de/hsync/vsync pixel stream.
- It is self-contained: it has its own line buffers and window logic, and does not depend on the separate erosion or dilation modules.

Parameters:
- H_SIZE, 83, total line period in pixel clocks, active plus blanking (10-bit). This is the line-buffer depth.

Ports:
- clk  input  1  pixel clock
- rst  input  1  synchronous reset, active-low (rst=0 resets on the clk rising edge)
- ce  input  1  clock enable; when 0, all state holds
- mask  input  1  input binary pixel, valid when in_de=1
- in_de  input  1  input data enable
- in_vsync  input  1  input vertical sync
- in_hsync  input  1  input horizontal sync
- opened  output  1  opened pixel
- out_de  output  1  in_de delayed to align with opened
- out_vsync  output  1  in_vsync delayed
- out_hsync  output  1  in_hsync delayed

Behaviour:
- Reset (rst=0, sampled on the clk edge):
  - All delay lines, line buffers, window registers and outputs clear to 0.
  - All stored de tags clear to 0, so every tap is invalid after reset.
- Advance: every cycle with ce=1, every pipeline element shifts by one, including during blanking. The line period is exactly H_SIZE.
- Each stage (erode, then dilate):
  - Two line buffers of H_SIZE entries each store {pixel, de} pairs.
  - Three 3-tap row shift registers form the 3x3 window.
  - The centre tap lags the newest tap by H_SIZE+1 cycles.
- Tap validity: a tap whose stored de=0 is replaced by the neutral value, 1 for erosion and 0 for dilation. This covers every frame border, including the first and last rows and columns, with no counters.
- Stage outputs (registered):
  - Erosion output = AND of the 9 substituted taps.
  - Dilation output = OR of the 9 substituted taps.
  - Stage de/hsync/vsync = centre-tap sync bits, registered alongside the pixel.
  - When the centre de=0, the stage output pixel is forced to 0.
- Latency:
  - Each stage: H_SIZE+2 enabled cycles.
  - Total mask-to-opened: 2*H_SIZE+4 (170 at default).
  - out_de, out_hsync and out_vsync are exactly in_de, in_hsync and in_vsync delayed by the same amount.
- ce=0 mid-frame: there is no shift and outputs hold their values. Resuming with ce=1 continues seamlessly.
- Reset mid-frame: the pipeline empties, and outputs are 0 for 2*H_SIZE+4 cycles after reset release. Taps holding post-reset zero tags are treated as out-of-frame.
- Invariants: opened=1 implies out_de=1. opened is never 1 where the input mask was 0 across the full 5x5 neighbourhood.

Optional Feature:
- Macro OPENING_STATS_EN.
- When defined:
  - Adds output fg_count (16-bit) and output fg_count_valid (1-bit).
  - An internal counter increments when ce && out_de && opened, saturating at 16'hFFFF.
  - On the rising edge of out_vsync (registered edge detect), the count is copied to fg_count, fg_count_valid pulses for 1 cycle, and the counter clears. An increment in the same cycle starts the new count at 1.
  - Reset clears all three.
- When undefined: these ports and the logic do not exist, and the core behaviour is identical.

Decomposition:
- Package morph_pkg:
  - OP_ERODE=0, OP_DILATE=1.
  - NEUTRAL(op) function.
  - STAGE_LAT(h) = h+2.
- Sub-module morph3x3_stage (parameters H_SIZE, OP):
  - Contains the line buffers, window, substitution and reduce logic.
  - Instantiated twice: erode, then dilate. The top level only chains the two stages and holds the optional stats logic.

Test Plan:
- Reset/latency: H_SIZE=10, 6 active + 4 blank per line. Single solid 3x3 block of ones mid-frame → opened equals the same 3x3 block, shifted by exactly 24 cycles. Sync outputs match their inputs delayed by 24.
- Speck removal: an isolated single 1 pixel, and separately a 1x3 horizontal line → opened is all 0 for the whole frame.
- Border: frame entirely ones (6x4 active) → output entirely ones. This includes corners, showing the neutral-1 erosion at borders.
- ce gating: toggle ce 1/0 every cycle over a 4x4 block frame → output sequence (sampled on ce=1 cycles) is identical to the ce=1 run.
- Mid-frame reset: assert rst=0 for 3 cycles during row 2 → all outputs 0 from the next edge. No 1 appears for the next 24 enabled cycles.
- Stats (OPENING_STATS_EN): 4x4 block of ones → fg_count=16 with a 1-cycle fg_count_valid pulse at the next out_vsync rise. Counter clears for the following frame.
